// File: rtl/cook_sequencer.sv
// ----------------------------------------------------------------------------
// cook_sequencer
//
// Control FSM for the oven's 4-digit MM:SS countdown timer. It shifts keypad
// digits into the timer, starts, pauses and clears the countdown, gates the
// magnetron, and raises a fixed-length beep once the countdown finishes.
//
// Ports
//   clk            in   system clock, rising-edge
//   rst            in   synchronous, active-high reset
//   key_valid      in   one-cycle strobe, key_digit is valid
//   key_digit      in   [3:0] BCD digit from the keypad
//   start          in   one-cycle strobe, start/resume
//   stop_clear     in   one-cycle strobe, pause when cooking, otherwise clear
//   door_closed    in   level, 1 = door closed
//   timer_finished in   level, timer has reached 00:00
//   timer_rst      out  one-cycle pulse that clears the timer
//   timer_load     out  one-cycle pulse, timer shifts timer_in in
//   timer_in       out  [3:0] digit for the timer, valid while timer_load=1
//   timer_enablen  out  active-low count enable to the timer
//   magnetron_on   out  heating element enable
//   beep           out  completion indicator
//   state          out  [2:0] current state (IDLE=0 ENTRY=1 COOK=2 PAUSE=3 DONE=4)
//
// Strobe semantics: key_valid, start and stop_clear are single-cycle strobes
// acted on in the cycle they are high; there is no back-pressure. Every
// output is registered, so a response appears on the edge that samples the
// input. Within a cycle, stop_clear beats door open, which beats start,
// which beats key_valid.
// ----------------------------------------------------------------------------
module cook_sequencer #(
  parameter int MAX_DIGITS  = 4,
  parameter int BEEP_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop_clear,
  input  logic       door_closed,
  input  logic       timer_finished,
  output logic       timer_rst,
  output logic       timer_load,
  output logic [3:0] timer_in,
  output logic       timer_enablen,
  output logic       magnetron_on,
  output logic       beep,
  output logic [2:0] state
);

  localparam int DW = $clog2(MAX_DIGITS + 1);
  localparam int BW = $clog2(BEEP_CYCLES + 1);

  localparam logic [DW-1:0] DIGIT_MAX = DW'(MAX_DIGITS);
  localparam logic [BW-1:0] BEEP_MAX  = BW'(BEEP_CYCLES);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ENTRY = 3'd1;
  localparam logic [2:0] S_COOK  = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [DW-1:0] digit_cnt_q, digit_cnt_d;
  logic [BW-1:0] beep_cnt_q, beep_cnt_d;
  logic          timer_rst_q, timer_rst_d;
  logic          timer_load_q, timer_load_d;
  logic [3:0]    timer_in_q, timer_in_d;
  logic          timer_enablen_q, timer_enablen_d;
  logic          magnetron_on_q, magnetron_on_d;
  logic          beep_q, beep_d;

  logic          digit_ok;

  assign digit_ok = key_valid && (key_digit <= 4'd9);

  always_comb begin
    // Defaults describe a quiet, non-cooking cycle: no pulses, counter off,
    // magnetron off. COOK and DONE override what they need.
    state_d         = state_q;
    digit_cnt_d     = digit_cnt_q;
    beep_cnt_d      = '0;
    timer_rst_d     = 1'b0;
    timer_load_d    = 1'b0;
    timer_in_d      = timer_in_q;
    timer_enablen_d = 1'b1;
    magnetron_on_d  = 1'b0;
    beep_d          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (stop_clear) begin
          timer_rst_d = 1'b1;
          digit_cnt_d = '0;
        end else if (digit_ok) begin
          // start is ignored here: there is no time entered yet.
          timer_load_d = 1'b1;
          timer_in_d   = key_digit;
          digit_cnt_d  = DW'(1);
          state_d      = S_ENTRY;
        end
      end

      S_ENTRY: begin
        if (stop_clear) begin
          timer_rst_d = 1'b1;
          digit_cnt_d = '0;
          state_d     = S_IDLE;
        end else if (start && door_closed) begin
          timer_enablen_d = 1'b0;
          magnetron_on_d  = 1'b1;
          state_d         = S_COOK;
        end else if (digit_ok && (digit_cnt_q < DIGIT_MAX)) begin
          timer_load_d = 1'b1;
          timer_in_d   = key_digit;
          digit_cnt_d  = digit_cnt_q + 1'b1;
        end
      end

      S_COOK: begin
        // Pausing wins over finishing; a finish seen together with a pause
        // is picked up again on the first COOK cycle after resume.
        if (stop_clear || !door_closed) begin
          state_d = S_PAUSE;
        end else if (timer_finished) begin
          beep_d     = 1'b1;
          beep_cnt_d = BW'(1);
          state_d    = S_DONE;
        end else begin
          timer_enablen_d = 1'b0;
          magnetron_on_d  = 1'b1;
        end
      end

      S_PAUSE: begin
        if (stop_clear) begin
          timer_rst_d = 1'b1;
          digit_cnt_d = '0;
          state_d     = S_IDLE;
        end else if (start && door_closed) begin
          timer_enablen_d = 1'b0;
          magnetron_on_d  = 1'b1;
          state_d         = S_COOK;
        end
      end

      S_DONE: begin
        // beep_cnt_q counts the beep cycles already shown (1..BEEP_MAX).
        if (stop_clear || (beep_cnt_q >= BEEP_MAX)) begin
          digit_cnt_d = '0;
          state_d     = S_IDLE;
        end else begin
          beep_d     = 1'b1;
          beep_cnt_d = beep_cnt_q + 1'b1;
        end
      end

      default: begin
        digit_cnt_d = '0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      digit_cnt_q     <= '0;
      beep_cnt_q      <= '0;
      timer_rst_q     <= 1'b0;
      timer_load_q    <= 1'b0;
      timer_in_q      <= 4'd0;
      timer_enablen_q <= 1'b1;
      magnetron_on_q  <= 1'b0;
      beep_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      digit_cnt_q     <= digit_cnt_d;
      beep_cnt_q      <= beep_cnt_d;
      timer_rst_q     <= timer_rst_d;
      timer_load_q    <= timer_load_d;
      timer_in_q      <= timer_in_d;
      timer_enablen_q <= timer_enablen_d;
      magnetron_on_q  <= magnetron_on_d;
      beep_q          <= beep_d;
    end
  end

  assign timer_rst     = timer_rst_q;
  assign timer_load    = timer_load_q;
  assign timer_in      = timer_in_q;
  assign timer_enablen = timer_enablen_q;
  assign magnetron_on  = magnetron_on_q;
  assign beep          = beep_q;
  assign state         = state_q;

endmodule

// File: tb/tb_cook_sequencer.sv
// ----------------------------------------------------------------------------
// tb_cook_sequencer
//
// Directed bench for cook_sequencer. Inputs change on the falling edge, the
// DUT samples on the rising edge, and outputs are read on the next falling
// edge. Digits the sequencer should forward are queued as they are keyed;
// a monitor pops one entry for each timer_load pulse it sees.
// ----------------------------------------------------------------------------
module tb_cook_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       start;
  logic       stop_clear;
  logic       door_closed;
  logic       timer_finished;
  logic       timer_rst;
  logic       timer_load;
  logic [3:0] timer_in;
  logic       timer_enablen;
  logic       magnetron_on;
  logic       beep;
  logic [2:0] state;

  int n_cmp = 0;
  int n_mis = 0;

  // Scoreboard: digits expected on timer_in, in order.
  logic [3:0] exp_q[$];
  int load_cnt = 0;
  int rst_cnt  = 0;
  logic prev_rst = 1'b0;

  // Bench-side entry model.
  int m_cnt     = 0;
  bit m_keys_ok = 1'b1;

  always #5 clk = ~clk;

  cook_sequencer #(.MAX_DIGITS(4), .BEEP_CYCLES(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .key_valid      (key_valid),
    .key_digit      (key_digit),
    .start          (start),
    .stop_clear     (stop_clear),
    .door_closed    (door_closed),
    .timer_finished (timer_finished),
    .timer_rst      (timer_rst),
    .timer_load     (timer_load),
    .timer_in       (timer_in),
    .timer_enablen  (timer_enablen),
    .magnetron_on   (magnetron_on),
    .beep           (beep),
    .state          (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: every load pulse must match the next queued digit; pulses
  // must never overlap and a clear pulse must last a single cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (timer_load) begin
        load_cnt++;
        if (exp_q.size() == 0) begin
          chk("load_unexpected", {28'd0, timer_in}, 32'hFFFF_FFFF);
        end else begin
          chk("load_digit", {28'd0, timer_in}, {28'd0, exp_q.pop_front()});
        end
        chk("load_rst_overlap", {31'd0, timer_rst}, 32'd0);
      end
      if (timer_rst) begin
        rst_cnt++;
        chk("rst_pulse_width", {31'd0, prev_rst}, 32'd0);
      end
      prev_rst = timer_rst;
    end else begin
      prev_rst = 1'b0;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic press(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    if (m_keys_ok && d <= 4'd9 && m_cnt < 4) begin
      exp_q.push_back(d);
      m_cnt++;
    end
    tick();
    key_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_clear = 1'b1;
    tick();
    stop_clear = 1'b0;
  endtask

  task automatic chk_outs(input string tag, input logic [2:0] st, input logic en_n,
                          input logic mag, input logic bp);
    chk({tag, "_state"},   {29'd0, state},         {29'd0, st});
    chk({tag, "_enablen"}, {31'd0, timer_enablen}, {31'd0, en_n});
    chk({tag, "_mag"},     {31'd0, magnetron_on},  {31'd0, mag});
    chk({tag, "_beep"},    {31'd0, beep},          {31'd0, bp});
  endtask

  int base_loads;
  int base_rsts;

  initial begin
    rst            = 1'b1;
    key_valid      = 1'b0;
    key_digit      = 4'd0;
    start          = 1'b0;
    stop_clear     = 1'b0;
    door_closed    = 1'b1;
    timer_finished = 1'b0;

    // Reset held for two cycles.
    tick();
    tick();
    rst = 1'b0;
    chk_outs("reset", 3'd0, 1'b1, 1'b0, 1'b0);
    chk("reset_load", {31'd0, timer_load}, 32'd0);
    chk("reset_trst", {31'd0, timer_rst}, 32'd0);
    chk("reset_tin",  {28'd0, timer_in}, 32'd0);

    // start with no time entered stays idle.
    pulse_start();
    chk_outs("idle_start", 3'd0, 1'b1, 1'b0, 1'b0);

    // Entry 1,3,0 then start.
    base_loads = load_cnt;
    press(4'd1);
    chk("entry_state", {29'd0, state}, 32'd1);
    press(4'd3);
    press(4'd0);
    pulse_start();
    m_keys_ok = 1'b0;
    chk_outs("cook", 3'd2, 1'b0, 1'b1, 1'b0);
    chk("entry_loads", load_cnt - base_loads, 32'd3);

    // Keys during cooking produce no load.
    press(4'd5);
    tick();
    chk("cook_key_ignored", load_cnt - base_loads, 32'd3);
    chk("cook_hold", {29'd0, state}, 32'd2);

    // Door opens during COOK.
    door_closed = 1'b0;
    tick();
    chk_outs("door_open", 3'd3, 1'b1, 1'b0, 1'b0);
    pulse_start();
    chk("pause_start_door_open", {29'd0, state}, 32'd3);
    door_closed = 1'b1;
    tick();
    chk("pause_door_closed", {29'd0, state}, 32'd3);
    pulse_start();
    chk_outs("resume", 3'd2, 1'b0, 1'b1, 1'b0);

    // Finish: three beep cycles then idle.
    timer_finished = 1'b1;
    tick();
    timer_finished = 1'b0;
    chk_outs("done1", 3'd4, 1'b1, 1'b0, 1'b1);
    tick();
    chk_outs("done2", 3'd4, 1'b1, 1'b0, 1'b1);
    tick();
    chk_outs("done3", 3'd4, 1'b1, 1'b0, 1'b1);
    tick();
    chk_outs("done_exit", 3'd0, 1'b1, 1'b0, 1'b0);
    m_keys_ok = 1'b1;
    m_cnt     = 0;

    // Overflow / invalid digits: only 1,2,3,4 reach the timer.
    base_loads = load_cnt;
    press(4'd1);
    press(4'd2);
    press(4'd3);
    press(4'd4);
    press(4'd5);
    press(4'hA);
    tick();
    chk("overflow_loads", load_cnt - base_loads, 32'd4);
    chk("overflow_state", {29'd0, state}, 32'd1);
    chk("overflow_queue_empty", exp_q.size(), 32'd0);

    // Clear from ENTRY.
    base_rsts = rst_cnt;
    pulse_stop();
    chk("entry_clear_pulse", {31'd0, timer_rst}, 32'd1);
    chk("entry_clear_state", {29'd0, state}, 32'd0);
    m_cnt = 0;
    tick();
    chk("entry_clear_count", rst_cnt - base_rsts, 32'd1);

    // Invalid digit in IDLE is ignored.
    press(4'hC);
    chk("idle_bad_digit", {29'd0, state}, 32'd0);

    // Door open and finished together in COOK: pause wins.
    press(4'd7);
    pulse_start();
    m_keys_ok = 1'b0;
    chk("cook2", {29'd0, state}, 32'd2);
    door_closed    = 1'b0;
    timer_finished = 1'b1;
    tick();
    chk_outs("pause_wins", 3'd3, 1'b1, 1'b0, 1'b0);
    tick();
    chk("pause_ignores_finished", {29'd0, state}, 32'd3);
    door_closed = 1'b1;

    // start and stop_clear together in PAUSE: clear wins.
    base_rsts  = rst_cnt;
    start      = 1'b1;
    stop_clear = 1'b1;
    tick();
    start      = 1'b0;
    stop_clear = 1'b0;
    chk("pause_clear_pulse", {31'd0, timer_rst}, 32'd1);
    chk_outs("pause_clear", 3'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("pause_clear_no_cook", {29'd0, state}, 32'd0);
    chk("pause_clear_count", rst_cnt - base_rsts, 32'd1);
    timer_finished = 1'b0;
    m_keys_ok = 1'b1;
    m_cnt     = 0;

    // Stop in DONE ends the beep early.
    press(4'd9);
    pulse_start();
    m_keys_ok = 1'b0;
    timer_finished = 1'b1;
    tick();
    timer_finished = 1'b0;
    chk("done_again", {29'd0, state}, 32'd4);
    pulse_stop();
    chk_outs("done_stop", 3'd0, 1'b1, 1'b0, 1'b0);
    m_keys_ok = 1'b1;
    m_cnt     = 0;

    // Reset mid-cook.
    press(4'd2);
    pulse_start();
    m_keys_ok = 1'b0;
    chk("cook3", {29'd0, state}, 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_outs("mid_reset", 3'd0, 1'b1, 1'b0, 1'b0);
    m_keys_ok = 1'b1;
    m_cnt     = 0;

    // Randomized short entry after reset.
    base_loads = load_cnt;
    for (int i = 0; i < 3; i++) begin
      press(4'($urandom_range(0, 9)));
    end
    tick();
    chk("rand_loads", load_cnt - base_loads, 32'd3);
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
